// File: rtl/line_buffer_sequencer.sv
// Write/shift/read sequencer for a 3-row line buffer.
// Optional: define LBSEQ_OVERRUN_CNT_EN to add o_overrun_count.
module line_buffer_sequencer #(
    parameter int LINE_WIDTH = 240,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_frame_start,
    input  logic [DATA_W-1:0] i_pixel_in,
    input  logic              i_pixel_valid,
    output logic              o_pixel_ready,
    output logic [DATA_W-1:0] o_data_in,
    output logic [ADDR_W-1:0] o_write_addr,
    output logic              o_write_en,
    output logic              o_shift,
    output logic [ADDR_W-1:0] o_read_addr,
    output logic              o_buf_reset,
    output logic              o_window_valid,
    output logic [ADDR_W-1:0] o_window_col,
    output logic              o_line_done,
    output logic [1:0]        o_lines_loaded
`ifdef LBSEQ_OVERRUN_CNT_EN
    ,
    output logic [15:0]       o_overrun_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FILL,
        S_FLUSH,
        S_SHIFT,
        S_READ
    } state_t;

    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(LINE_WIDTH - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_col;
    logic                r_pixel_ready;
    logic [DATA_W-1:0]   r_data_in;
    logic [ADDR_W-1:0]   r_write_addr;
    logic                r_write_en;
    logic                r_shift;
    logic [ADDR_W-1:0]   r_read_addr;
    logic                r_buf_reset;
    logic                r_window_valid;
    logic [ADDR_W-1:0]   r_window_col;
    logic                r_line_done;
    logic [1:0]          r_lines_loaded;

    logic w_start;
    logic w_accept;

    assign w_start  = i_frame_start && (r_state != S_CLEAR);
    assign w_accept = (r_state == S_FILL) && i_pixel_valid && r_pixel_ready;

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_col          <= '0;
            r_pixel_ready  <= 1'b0;
            r_data_in      <= '0;
            r_write_addr   <= '0;
            r_write_en     <= 1'b0;
            r_shift        <= 1'b0;
            r_read_addr    <= '0;
            r_buf_reset    <= 1'b0;
            r_window_valid <= 1'b0;
            r_window_col   <= '0;
            r_line_done    <= 1'b0;
            r_lines_loaded <= '0;
        end else begin
            r_write_en     <= 1'b0;
            r_shift        <= 1'b0;
            r_buf_reset    <= 1'b0;
            r_window_valid <= 1'b0;
            r_line_done    <= 1'b0;
            if (w_start) begin
                // Abort whatever is in flight; partial line is dropped.
                r_state        <= S_CLEAR;
                r_buf_reset    <= 1'b1;
                r_pixel_ready  <= 1'b0;
                r_lines_loaded <= '0;
                r_col          <= '0;
                r_read_addr    <= '0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_pixel_ready <= 1'b0;
                    end
                    S_CLEAR: begin
                        r_state        <= S_FILL;
                        r_pixel_ready  <= 1'b1;
                        r_col          <= '0;
                        r_lines_loaded <= '0;
                    end
                    S_FILL: begin
                        if (w_accept) begin
                            r_write_en   <= 1'b1;
                            r_write_addr <= r_col;
                            r_data_in    <= i_pixel_in;
                            if (r_col == LP_LAST) begin
                                r_state       <= S_FLUSH;
                                r_pixel_ready <= 1'b0;
                                r_col         <= '0;
                            end else begin
                                r_col <= r_col + ADDR_W'(1);
                            end
                        end
                    end
                    S_FLUSH: begin
                        // Last write lands this cycle; shift follows.
                        r_state <= S_SHIFT;
                        r_shift <= 1'b1;
                        if (r_lines_loaded != 2'd3) begin
                            r_lines_loaded <= r_lines_loaded + 2'd1;
                        end
                    end
                    S_SHIFT: begin
                        if (r_lines_loaded == 2'd3) begin
                            r_state     <= S_READ;
                            r_read_addr <= '0;
                        end else begin
                            r_state       <= S_FILL;
                            r_col         <= '0;
                            r_pixel_ready <= 1'b1;
                        end
                    end
                    S_READ: begin
                        // Buffer data lags the address by one cycle.
                        r_window_valid <= 1'b1;
                        r_window_col   <= r_read_addr;
                        r_line_done    <= (r_read_addr == LP_LAST);
                        if (r_read_addr == LP_LAST) begin
                            r_state       <= S_FILL;
                            r_read_addr   <= '0;
                            r_col         <= '0;
                            r_pixel_ready <= 1'b1;
                        end else begin
                            r_read_addr <= r_read_addr + ADDR_W'(1);
                        end
                    end
                    default: begin
                        r_state       <= S_IDLE;
                        r_pixel_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef LBSEQ_OVERRUN_CNT_EN
    logic [15:0] r_overrun_count;

    // Count offered pixels that could not be taken, saturating.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overrun_count <= '0;
        end else if (r_state == S_CLEAR) begin
            r_overrun_count <= '0;
        end else if ((r_state != S_IDLE) && i_pixel_valid &&
                     !r_pixel_ready && (r_overrun_count != 16'hFFFF)) begin
            r_overrun_count <= r_overrun_count + 16'd1;
        end
    end

    assign o_overrun_count = r_overrun_count;
`endif

    assign o_pixel_ready  = r_pixel_ready;
    assign o_data_in      = r_data_in;
    assign o_write_addr   = r_write_addr;
    assign o_write_en     = r_write_en;
    assign o_shift        = r_shift;
    assign o_read_addr    = r_read_addr;
    assign o_buf_reset    = r_buf_reset;
    assign o_window_valid = r_window_valid;
    assign o_window_col   = r_window_col;
    assign o_line_done    = r_line_done;
    assign o_lines_loaded = r_lines_loaded;

endmodule

// File: tb/tb_line_buffer_sequencer.sv
// Directed self-checking bench for line_buffer_sequencer.
// Honours LBSEQ_OVERRUN_CNT_EN when defined.
module tb_line_buffer_sequencer;

    localparam int LW = 240;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fs = 1'b0;
    logic [7:0] pin = '0;
    logic       pv = 1'b0;
    logic       pr;
    logic [7:0] di;
    logic [7:0] wa;
    logic       we;
    logic       sh;
    logic [7:0] ra;
    logic       br;
    logic       wv;
    logic [7:0] wc;
    logic       ld;
    logic [1:0] ll;
`ifdef LBSEQ_OVERRUN_CNT_EN
    logic [15:0] oc;
`endif

    int n_cmp = 0;
    int n_err = 0;

    line_buffer_sequencer #(
        .LINE_WIDTH(LW),
        .ADDR_W(8),
        .DATA_W(8)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_frame_start(fs),
        .i_pixel_in(pin),
        .i_pixel_valid(pv),
        .o_pixel_ready(pr),
        .o_data_in(di),
        .o_write_addr(wa),
        .o_write_en(we),
        .o_shift(sh),
        .o_read_addr(ra),
        .o_buf_reset(br),
        .o_window_valid(wv),
        .o_window_col(wc),
        .o_line_done(ld),
        .o_lines_loaded(ll)
`ifdef LBSEQ_OVERRUN_CNT_EN
        ,
        .o_overrun_count(oc)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pix(input int mode, input int i);
        case (mode)
            0: return 8'(i);
            1: return 8'(239 - i);
            2: return 8'(i + 1);
            3: return 8'(i) ^ 8'h5A;
            default: return 8'h07;
        endcase
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; fs = 1'b0; pv = 1'b0;
        repeat (3) tick();
        n_cmp++; if (pr !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", pr); end
        n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL rst_we got %b want 0", we); end
        n_cmp++; if (sh !== 1'b0) begin n_err++; $display("FAIL rst_shift got %b want 0", sh); end
        n_cmp++; if (br !== 1'b0) begin n_err++; $display("FAIL rst_bufreset got %b want 0", br); end
        n_cmp++; if (wv !== 1'b0 || ld !== 1'b0) begin n_err++; $display("FAIL rst_window got wv=%b ld=%b want 0 0", wv, ld); end
        n_cmp++; if (ll !== 2'd0) begin n_err++; $display("FAIL rst_lines got %0d want 0", ll); end
        n_cmp++; if ({ra, wa, di, wc} !== 32'd0) begin n_err++; $display("FAIL rst_buses got ra=%0d wa=%0d di=%0d wc=%0d want 0", ra, wa, di, wc); end
        rst_n = 1'b1;
        tick(); tick();
        n_cmp++; if (pr !== 1'b0 || br !== 1'b0) begin n_err++; $display("FAIL idle_wait got pr=%b br=%b want 0 0", pr, br); end
    endtask

    task automatic test_frame_start;
        fs = 1'b1;
        tick();
        fs = 1'b0;
        n_cmp++; if (br !== 1'b1) begin n_err++; $display("FAIL clear_bufreset got %b want 1", br); end
        n_cmp++; if (ll !== 2'd0) begin n_err++; $display("FAIL clear_lines got %0d want 0", ll); end
        n_cmp++; if (pr !== 1'b0) begin n_err++; $display("FAIL clear_ready got %b want 0", pr); end
        tick();
        n_cmp++; if (br !== 1'b0) begin n_err++; $display("FAIL clear_one_cycle got %b want 0", br); end
        n_cmp++; if (pr !== 1'b1) begin n_err++; $display("FAIL fill_ready got %b want 1", pr); end
    endtask

    task automatic feed_line(input int mode, input int gap, input logic keep_valid,
                             input logic [1:0] exp_ll, input logic exp_read);
        for (int i = 0; i < LW; i++) begin
            for (int g = 0; g < gap; g++) begin
                pv = 1'b0;
                tick();
                n_cmp++; if (we !== 1'b0 || sh !== 1'b0) begin n_err++; $display("FAIL gap_we i=%0d got we=%b sh=%b want 0 0", i, we, sh); end
            end
            n_cmp++; if (pr !== 1'b1) begin n_err++; $display("FAIL feed_ready i=%0d got %b want 1", i, pr); end
            pv = 1'b1;
            pin = pix(mode, i);
            tick();
            n_cmp++;
            if (we !== 1'b1 || wa !== 8'(i) || di !== pix(mode, i) || sh !== 1'b0) begin
                n_err++;
                $display("FAIL write m=%0d i=%0d got we=%b wa=%0d di=%0d sh=%b want 1 %0d %0d 0",
                         mode, i, we, wa, di, sh, i, pix(mode, i));
            end
        end
        pv = keep_valid;
        n_cmp++; if (pr !== 1'b0) begin n_err++; $display("FAIL flush_ready got %b want 0", pr); end
        tick();
        n_cmp++; if (sh !== 1'b1 || we !== 1'b0) begin n_err++; $display("FAIL shift got sh=%b we=%b want 1 0", sh, we); end
        n_cmp++; if (ll !== exp_ll) begin n_err++; $display("FAIL lines got %0d want %0d", ll, exp_ll); end
        tick();
        n_cmp++; if (sh !== 1'b0) begin n_err++; $display("FAIL shift_once got %b want 0", sh); end
        n_cmp++; if (pr !== !exp_read) begin n_err++; $display("FAIL post_shift_ready got %b want %b", pr, !exp_read); end
        n_cmp++; if (ra !== 8'd0 || wv !== 1'b0) begin n_err++; $display("FAIL post_shift_read got ra=%0d wv=%b want 0 0", ra, wv); end
    endtask

    task automatic test_single_line;
        feed_line(0, 0, 1'b0, 2'd1, 1'b0);
    endtask

    task automatic test_three_lines;
        test_frame_start();
        feed_line(0, 0, 1'b0, 2'd1, 1'b0);
        feed_line(1, 0, 1'b0, 2'd2, 1'b0);
`ifdef LBSEQ_OVERRUN_CNT_EN
        n_cmp++; if (oc !== 16'd0) begin n_err++; $display("FAIL overrun_pre got %0d want 0", oc); end
`endif
        feed_line(2, 0, 1'b1, 2'd3, 1'b1);
        for (int k = 1; k < LW; k++) begin
            tick();
            n_cmp++;
            if (ra !== 8'(k) || wv !== 1'b1 || wc !== 8'(k - 1) || ld !== 1'b0 ||
                pr !== 1'b0 || we !== 1'b0) begin
                n_err++;
                $display("FAIL read k=%0d got ra=%0d wv=%b wc=%0d ld=%b pr=%b we=%b want %0d 1 %0d 0 0 0",
                         k, ra, wv, wc, ld, pr, we, k, k - 1);
            end
        end
        tick();
        n_cmp++;
        if (wv !== 1'b1 || wc !== 8'd239 || ld !== 1'b1 || pr !== 1'b1 || ra !== 8'd0) begin
            n_err++;
            $display("FAIL last_col got wv=%b wc=%0d ld=%b pr=%b ra=%0d want 1 239 1 1 0", wv, wc, ld, pr, ra);
        end
`ifdef LBSEQ_OVERRUN_CNT_EN
        n_cmp++; if (oc !== 16'd242) begin n_err++; $display("FAIL overrun_cnt got %0d want 242", oc); end
`endif
        pv = 1'b0;
    endtask

    task automatic test_back_to_back;
        feed_line(4, 0, 1'b0, 2'd3, 1'b1);
        tick();
        n_cmp++; if (ra !== 8'd1 || wv !== 1'b1 || wc !== 8'd0) begin n_err++; $display("FAIL b2b_read got ra=%0d wv=%b wc=%0d want 1 1 0", ra, wv, wc); end
        fs = 1'b1;
        tick();
        fs = 1'b0;
        n_cmp++; if (wv !== 1'b0 || ld !== 1'b0) begin n_err++; $display("FAIL abort_read_wv got wv=%b ld=%b want 0 0", wv, ld); end
        n_cmp++; if (br !== 1'b1 || ra !== 8'd0 || ll !== 2'd0) begin n_err++; $display("FAIL abort_read_clear got br=%b ra=%0d ll=%0d want 1 0 0", br, ra, ll); end
        tick();
        n_cmp++; if (pr !== 1'b1 || br !== 1'b0) begin n_err++; $display("FAIL abort_read_fill got pr=%b br=%b want 1 0", pr, br); end
`ifdef LBSEQ_OVERRUN_CNT_EN
        n_cmp++; if (oc !== 16'd0) begin n_err++; $display("FAIL overrun_clear got %0d want 0", oc); end
`endif
    endtask

    task automatic test_gapped;
        test_frame_start();
        feed_line(3, 2, 1'b0, 2'd1, 1'b0);
    endtask

    task automatic test_abort;
        for (int i = 0; i < 100; i++) begin
            pv = 1'b1;
            pin = 8'(i + 50);
            tick();
            n_cmp++; if (we !== 1'b1 || wa !== 8'(i)) begin n_err++; $display("FAIL abort_pre i=%0d got we=%b wa=%0d want 1 %0d", i, we, wa, i); end
        end
        pv = 1'b0;
        tick();
        fs = 1'b1; pv = 1'b1; pin = 8'hEE;
        n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL abort_fs_cycle_we got %b want 0", we); end
        tick();
        fs = 1'b0; pv = 1'b0;
        n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL abort_we got %b want 0", we); end
        n_cmp++; if (br !== 1'b1 || ll !== 2'd0) begin n_err++; $display("FAIL abort_clear got br=%b ll=%0d want 1 0", br, ll); end
        tick();
        n_cmp++; if (we !== 1'b0 || pr !== 1'b1) begin n_err++; $display("FAIL abort_fill got we=%b pr=%b want 0 1", we, pr); end
        pv = 1'b1; pin = 8'h33;
        tick();
        pv = 1'b0;
        n_cmp++; if (we !== 1'b1 || wa !== 8'd0 || di !== 8'h33) begin n_err++; $display("FAIL abort_restart got we=%b wa=%0d di=%0d want 1 0 51", we, wa, di); end
    endtask

    task automatic test_async_reset;
        pv = 1'b1; pin = 8'h44;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (we !== 1'b0 || pr !== 1'b0 || wa !== 8'd0 || di !== 8'd0) begin n_err++; $display("FAIL async_rst got we=%b pr=%b wa=%0d di=%0d want 0 0 0 0", we, pr, wa, di); end
        pv = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (pr !== 1'b0 || br !== 1'b0 || ll !== 2'd0) begin n_err++; $display("FAIL post_rst_idle got pr=%b br=%b ll=%0d want 0 0 0", pr, br, ll); end
    endtask

    initial begin
        test_reset();
        test_frame_start();
        test_single_line();
        test_three_lines();
        test_back_to_back();
        test_gapped();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/line_buffer_sequencer.md
Name: line_buffer_sequencer

Overview:
- Controls the 3-row, 8-bit line buffer for a stream of raster pixels.
- Accepts pixels over a valid/ready handshake and writes each line into the buffer, then issues the row Shift.
- Once three lines are resident, sweeps ReadAddr across the line and flags when the 3-row column window on the buffer's Data outputs is valid.
- Also generates the buffer's synchronous Reset at frame start.

Parameters:
- LINE_WIDTH, 240, pixels per line; range 2..256.
- ADDR_W, 8, buffer address width.
- DATA_W, 8, pixel width.

Ports:
- Clock  in  1  single system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset; clears all state immediately.
- FrameStart  in  1  one-cycle pulse that begins a new frame.
- PixelIn  in  DATA_W  input pixel.
- PixelValid  in  1  PixelIn is valid.
- PixelReady  out  1  sequencer accepts PixelIn this cycle.
- DataIn  out  DATA_W  buffer write data.
- WriteAddr  out  ADDR_W  buffer write address.
- WriteEn  out  1  buffer write strobe.
- Shift  out  1  buffer row-shift strobe.
- ReadAddr  out  ADDR_W  buffer read address.
- BufReset  out  1  buffer synchronous clear (active-high).
- WindowValid  out  1  buffer Data[0..2] holds a valid column this cycle.
- WindowCol  out  ADDR_W  column index of the current window.
- LineDone  out  1  one-cycle pulse with the last window column of a line.
- LinesLoaded  out  2  saturating count of lines shifted in (0..3).

Behaviour:
- All outputs are registered.
- Reset values: every output 0; state IDLE; column counter 0; LinesLoaded 0.
- States are IDLE, CLEAR, FILL, FLUSH, SHIFT and READ.
- IDLE: PixelReady=0. FrameStart moves the sequencer to CLEAR.
- CLEAR: BufReset=1 for exactly one cycle; LinesLoaded:=0; column counter:=0; next state FILL.
- FILL: PixelReady=1.
  - On PixelValid&&PixelReady, the registered write appears the next cycle: WriteEn=1, WriteAddr=col, DataIn=PixelIn. Then col increments.
  - PixelValid=0 gives WriteEn=0 next cycle and col holds.
  - Acceptance at col=LINE_WIDTH-1 moves to FLUSH.
- FLUSH: one cycle; PixelReady=0; the last write lands. Next state SHIFT.
  - This guarantees WriteEn and Shift are never high in the same cycle.
- SHIFT: Shift=1 for one cycle; LinesLoaded saturates at 3.
  - Next state READ if LinesLoaded (after update) equals 3, else FILL with col:=0.
- READ: PixelReady=0; ReadAddr steps 0..LINE_WIDTH-1, one per cycle, with no stalls.
  - Buffer read latency is 1 cycle, so WindowValid=1 and WindowCol=previous ReadAddr one cycle after each address is issued.
  - LineDone=1 with WindowCol=LINE_WIDTH-1.
  - After the last address is issued, next state FILL with col:=0. The final WindowValid/LineDone falls in the first FILL cycle.
- Line period once primed: LINE_WIDTH accept cycles + 1 FLUSH + 1 SHIFT + LINE_WIDTH READ.
- Counters wrap nowhere: col is compared against LINE_WIDTH-1 and reloaded to 0; ReadAddr is held at 0 outside READ.
- FrameStart in any non-IDLE state aborts the current operation:
  - goes to CLEAR next cycle;
  - any pending WriteEn/WindowValid/LineDone is suppressed (forced 0 from that cycle);
  - a partial line is discarded.
- FrameStart is ignored while already in CLEAR.
- Asynchronous Reset asserted mid-line forces the reset values above at once; after release the sequencer waits in IDLE for FrameStart.

Optional Feature:
- Macro: LBSEQ_OVERRUN_CNT_EN.
- With the macro defined: adds output OverrunCount (16 bits, reset 0).
  - Increments each cycle PixelValid=1 && PixelReady=0 while not in IDLE; saturates at 0xFFFF.
  - Cleared in CLEAR.
- Without the macro: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset low for 3 cycles, release, then FrameStart -> BufReset=1 for exactly 1 cycle; LinesLoaded=0; PixelReady=1 from the following cycle.
- LINE_WIDTH=240; stream pixels 0..239 with PixelValid held high -> WriteEn on 240 consecutive cycles with WriteAddr=DataIn=i; 1 FLUSH cycle; Shift=1 once; LinesLoaded=1; no READ.
- Three full lines (data i, 239-i, i+1) -> after the third Shift, ReadAddr runs 0..239:
  - WindowValid on 240 consecutive cycles with WindowCol lagging ReadAddr by 1;
  - LineDone at col 239;
  - PixelReady=0 throughout READ.
- Gapped input (PixelValid 1-of-3 cycles) -> WriteAddr still dense 0..239, no duplicate or skipped writes, Shift only after the 240th write.
- FrameStart mid-FILL at col 100 -> WriteEn=0 from that cycle, BufReset next cycle, next write uses WriteAddr=0, LinesLoaded=0.
- With LBSEQ_OVERRUN_CNT_EN, hold PixelValid=1 across FLUSH+SHIFT+240-cycle READ -> OverrunCount=242; CLEAR resets it to 0.
